// File: rtl/div_fsm_pkg.sv
// rtl/div_fsm_pkg.sv - shared state encodings and default constants for divide-by-N generators/checkers
package div_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACQ    = 2'b01,
      ST_LOCKED = 2'b10
   } state_e;

   localparam int DEF_DIV        = 3;
   localparam int DEF_LOCK_COUNT = 4;

   // Bits needed to hold a match count of 0..n inclusive.
   function automatic int match_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q = count_q;

endmodule

// File: rtl/div_strobe_checker.sv
// rtl/div_strobe_checker.sv - measures strobe spacing against DIV, reports lock and counts deviations
module div_strobe_checker
   import div_fsm_pkg::*;
#(
   parameter int DIV        = DEF_DIV,
   parameter int CNT_W      = 4,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strb,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] period,
   output logic [ERR_W-1:0] err_count
);

   localparam int MATCH_W = match_width(LOCK_COUNT);
   localparam logic [CNT_W-1:0]   DIV_M1  = CNT_W'(DIV - 1);
   localparam logic [MATCH_W-1:0] LOCK_M1 = MATCH_W'(LOCK_COUNT - 1);

   state_e             state_q, state_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   period_q, period_d;

   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_p1;
   logic               active, at_div, good, early, missed, bad;

   // Idle cycles since the last strobe; runs in every state so IDLE exits cleanly.
   sat_counter #(.W(CNT_W)) u_gap_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (strb),
      .inc   (~strb),
      .q     (cnt)
   );

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .inc   (bad),
      .q     (err_count)
   );

   always_comb begin
      active = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
      at_div = (cnt == DIV_M1);
      good   = active &&  strb &&  at_div;
      early  = active &&  strb && !at_div;
      missed = active && !strb &&  at_div;
      bad    = early || missed;
      cnt_p1 = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         match_q  <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         period_q <= period_d;
      end
   end

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      case (state_q)
         ST_IDLE: begin
            if (strb) begin
               state_d = ST_ACQ;
               match_d = '0;
            end
         end
         ST_ACQ: begin
            if (good) begin
               match_d = match_q + 1'b1;
               if (match_q == LOCK_M1) begin
                  state_d = ST_LOCKED;
               end
            end else if (early) begin
               match_d = '0;
            end else if (missed) begin
               state_d = ST_IDLE;
               match_d = '0;
            end
         end
         ST_LOCKED: begin
            if (early) begin
               state_d = ST_ACQ;
               match_d = '0;
            end else if (missed) begin
               state_d = ST_IDLE;
               match_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            match_d = '0;
         end
      endcase
   end

   // Decoding the next state keeps locked aligned with the state register.
   always_comb begin
      locked_d = (state_d == ST_LOCKED);
      err_d    = bad;
      period_d = (active && strb) ? cnt_p1 : period_q;
   end

   assign locked = locked_q;
   assign err    = err_q;
   assign period = period_q;

endmodule
